// File: rtl/beacon_blink_seq.sv
// -----------------------------------------------------------------------------
// beacon_blink_seq
//
// Pattern sequencer for the beacon LED. It consumes the single-cycle bit-time
// strobe from the upstream tick generator and shifts a latched on/off code out
// on `led`, one bit per tick, MSB first. The code is repeated `reps` times
// (or forever when `reps` == 0) with one dark tick between repetitions.
//
// Parameters
//   PAT_LEN  pattern length in bits (>= 2)
//   REP_W    width of the repetition count
//   IDX_W    width of the bit index
//
// Ports
//   clk      in   clock
//   rst      in   synchronous, active-high reset
//   tick     in   bit-time strobe, single-cycle pulse
//   start    in   request a run; only honoured while idle
//   stop     in   abort any run in progress
//   pattern  in   code to emit, captured on an accepted start
//   reps     in   repetition count, captured on an accepted start; 0 = forever
//   led      out  registered LED drive
//   busy     out  high whenever a run is armed or in progress
//   done     out  one-cycle pulse on natural completion of a run
//   bit_idx  out  index of the bit currently on `led`; 0 outside RUN
// -----------------------------------------------------------------------------
module beacon_blink_seq #(
  parameter int PAT_LEN = 16,
  parameter int REP_W   = 8,
  parameter int IDX_W   = $clog2(PAT_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [REP_W-1:0]   reps,
  output logic               led,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   bit_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for start
    ARM  = 2'd1,  // run accepted, waiting for the next tick to align
    RUN  = 2'd2,  // shifting pattern bits out
    GAP  = 2'd3   // one dark tick between repetitions
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
  localparam logic [REP_W-1:0] ONE_REP  = REP_W'(1);

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q,   pat_d;
  logic [REP_W-1:0]   rep_q,   rep_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               cont_q,  cont_d;
  logic               led_q,   led_d;
  logic               done_q,  done_d;

  // Next-state and next-register computation. Every register has a "_d"
  // shadow so the whole datapath updates in a single clocked process.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned -- otherwise synthesis infers a latch.
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    cont_d  = cont_q;
    led_d   = led_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A tick arriving together with start is ignored: ARM waits for the
        // next one so the first bit is always a full tick period long.
        if (start) begin
          pat_d   = pattern;
          rep_d   = reps;
          cont_d  = (reps == '0);
          idx_d   = '0;
          led_d   = 1'b0;
          state_d = ARM;
        end
      end

      ARM, GAP: begin
        if (tick) begin
          idx_d   = LAST_IDX;
          led_d   = pat_q[PAT_LEN-1];
          state_d = RUN;
        end
      end

      RUN: begin
        if (tick) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
            led_d = pat_q[idx_q - IDX_W'(1)];
          end else if (cont_q || (rep_q > ONE_REP)) begin
            // Continuous mode leaves the count untouched; otherwise the
            // count only ever steps down while it is above one, so it
            // cannot wrap.
            if (!cont_q) begin
              rep_d = rep_q - ONE_REP;
            end
            led_d   = 1'b0;
            state_d = GAP;
          end else begin
            led_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase

    // Abort overrides any tick-driven transition in the same cycle and never
    // produces a done pulse.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      led_d   = 1'b0;
      done_d  = 1'b0;
      rep_d   = '0;
      cont_d  = 1'b0;
      idx_d   = '0;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      cont_q  <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      cont_q  <= cont_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // done is registered alongside the IDLE transition, so it rises in the same
  // cycle that busy falls and led returns dark.
  assign led     = led_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign bit_idx = (state_q == RUN) ? idx_q : '0;

endmodule

// File: tb/tb_beacon_blink_seq.sv
// -----------------------------------------------------------------------------
// tb_beacon_blink_seq
//
// Directed bench for beacon_blink_seq with PAT_LEN = 8. Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point, so each
// step() shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_beacon_blink_seq;

  localparam int PAT_LEN = 8;
  localparam int REP_W   = 8;
  localparam int IDX_W   = 3;

  logic               clk;
  logic               rst;
  logic               tick;
  logic               start;
  logic               stop;
  logic [PAT_LEN-1:0] pattern;
  logic [REP_W-1:0]   reps;
  logic               led;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   bit_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  beacon_blink_seq #(
    .PAT_LEN (PAT_LEN),
    .REP_W   (REP_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .start   (start),
    .stop    (stop),
    .pattern (pattern),
    .reps    (reps),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .bit_idx (bit_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle in which done is high.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Emits bits hi..lo of pat, one tick per bit, tick period 4 clk. Checks the
  // bit right after the tick and again at the end of its hold time.
  task automatic emit_range(input logic [PAT_LEN-1:0] pat, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("led_bit",  {31'd0, led}, {31'd0, pat[i]});
      check("bit_idx",  {29'd0, bit_idx}, 32'(i));
      check("busy_run", {31'd0, busy}, 32'd1);
      repeat (3) step();
      check("led_hold", {31'd0, led}, {31'd0, pat[i]});
    end
  endtask

  task automatic gap_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("gap_led",  {31'd0, led}, 32'd0);
    check("gap_busy", {31'd0, busy}, 32'd1);
    check("gap_done", {31'd0, done}, 32'd0);
    check("gap_idx",  {29'd0, bit_idx}, 32'd0);
    repeat (3) step();
  endtask

  task automatic end_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("end_led",  {31'd0, led}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_done", {31'd0, done}, 32'd1);
    step();
    check("done_pulse_1cyc", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    pattern = '0; reps = '0;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    check("rst_led",  {31'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_idx",  {29'd0, bit_idx}, 32'd0);

    // 1) Single copy of 1011_0001
    pattern = 8'b1011_0001; reps = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_arm", {31'd0, busy}, 32'd1);
    check("t1_led_arm",  {31'd0, led}, 32'd0);
    repeat (2) step();
    emit_range(8'b1011_0001, 7, 0);
    end_tick();
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2) Three copies with dark gaps in between
    pattern = 8'b1011_0001; reps = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    emit_range(8'b1011_0001, 7, 0);
    gap_tick();
    emit_range(8'b1011_0001, 7, 0);
    gap_tick();
    emit_range(8'b1011_0001, 7, 0);
    end_tick();
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // 3) Continuous 0xFF for 50 ticks, then stop coinciding with a tick
    pattern = 8'hFF; reps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < 50; p++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("t3_led", {31'd0, led}, ((p % 9) == 8) ? 32'd0 : 32'd1);
      repeat (3) step();
    end
    check("t3_busy_before_stop", {31'd0, busy}, 32'd1);
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    check("t3_stop_led",  {31'd0, led}, 32'd0);
    check("t3_stop_busy", {31'd0, busy}, 32'd0);
    check("t3_stop_done", {31'd0, done}, 32'd0);
    step();
    check("t3_done_cnt", 32'(done_cnt), 32'd2);

    // 4) Start together with a tick; restart attempt mid-run is ignored
    pattern = 8'hA5; reps = 8'd1; start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    check("t4_busy_arm", {31'd0, busy}, 32'd1);
    check("t4_led_arm",  {31'd0, led}, 32'd0);
    check("t4_idx_arm",  {29'd0, bit_idx}, 32'd0);
    repeat (3) step();
    emit_range(8'hA5, 7, 4);
    pattern = 8'h00; reps = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_idx",  {29'd0, bit_idx}, 32'd4);
    check("t4_restart_busy", {31'd0, busy}, 32'd1);
    repeat (2) step();
    emit_range(8'hA5, 3, 0);
    end_tick();
    check("t4_done_cnt", 32'(done_cnt), 32'd3);

    // 5) Reset during bit 5 of the second repetition, then a clean run
    pattern = 8'b1011_0001; reps = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    emit_range(8'b1011_0001, 7, 0);
    gap_tick();
    emit_range(8'b1011_0001, 7, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_led",  {31'd0, led}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_idx",  {29'd0, bit_idx}, 32'd0);
    step();
    check("t5_done_cnt_rst", 32'(done_cnt), 32'd3);
    pattern = 8'b1011_0001; reps = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t5_busy_arm", {31'd0, busy}, 32'd1);
    emit_range(8'b1011_0001, 7, 0);
    end_tick();
    check("t5_done_cnt", 32'(done_cnt), 32'd4);

    // 6) No tick for 100 clk after start: stays armed and dark
    pattern = 8'hFF; reps = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_led",  {31'd0, led}, 32'd0);
    check("t6_idx",  {29'd0, bit_idx}, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t6_stop_busy", {31'd0, busy}, 32'd0);
    // stop while idle leaves everything quiet
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t6_idle_stop_busy", {31'd0, busy}, 32'd0);
    check("t6_done_cnt", 32'(done_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/beacon_blink_seq.md
# beacon_blink_seq

Pattern sequencer that sits directly downstream of the beacon tick generator: it consumes the periodic single-cycle `tick` and shifts a latched on/off code out to the beacon LED driver, one bit per tick, MSB first. It repeats the code a programmed number of times, or continuously, and inserts a one-tick dark gap between repetitions. It reports progress to the control logic through `busy`/`done`. The tick period therefore sets the bit time and is owned entirely by the upstream block.

## Interface
- `PAT_LEN`, default 16: pattern length in bits (≥2).
- `REP_W`, default 8: width of the repetition count.
- `IDX_W`, default $clog2(PAT_LEN): width of the bit index.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  bit-time strobe from the upstream tick generator; single-cycle pulse.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort any run in progress.
- `pattern`  in  PAT_LEN  code to emit; latched on an accepted start.
- `reps`  in  REP_W  repetitions to emit; latched on an accepted start; 0 = continuous.
- `led`  out  1  registered LED drive.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural completion.
- `bit_idx`  out  IDX_W  index of the bit currently on `led`; 0 when not in RUN.

## Operation
- Internal registers: `pat_q` (PAT_LEN bits), `rep_q` (REP_W bits), `idx` (IDX_W bits), `cont` (1 bit; set when the latched reps == 0). All are latched together on an accepted start.
- States and transitions:
  - IDLE:
    - `led`=0, `busy`=0.
    - `start`=1 → latch the registers, go to ARM.
    - A tick in the same cycle is ignored.
  - ARM:
    - Waits for alignment to the tick grid.
    - On tick: `idx`←PAT_LEN-1, `led`←`pat_q`[PAT_LEN-1], go to RUN.
  - RUN:
    - On tick with `idx`≠0: `idx`←`idx`-1, `led`←`pat_q`[`idx`-1].
    - On tick with `idx`=0, if `cont`=1 or `rep_q`>1: decrement `rep_q` (not when `cont`=1), set `led`←0, go to GAP.
    - On tick with `idx`=0 otherwise: set `led`←0, pulse `done`, go to IDLE.
  - GAP:
    - On tick: `idx`←PAT_LEN-1, `led`←`pat_q`[PAT_LEN-1], go to RUN.
- Priority:
  - `stop` beats `tick` in the same cycle.
  - Any non-IDLE state with `stop`=1 goes to IDLE next cycle with `led`=0. No `done` pulse; `rep_q` and `cont` are cleared.
  - `stop` in IDLE has no effect.
- `start` while `busy`=1 is ignored. `pattern`/`reps` changes after latching have no effect on the current run.
- `rep_q` never wraps. The decrement happens only when `rep_q`>1.

## Timing
- Reset values: `led`=0, `busy`=0, `done`=0, `bit_idx`=0, state=IDLE, all internal registers 0.
- Reset mid-run behaves like `stop` but takes priority over everything.
- Start latency:
  - `start` at cycle c → `busy`=1 at c+1.
  - The first bit appears on `led` the cycle after the first tick sampled at or after c+1.
- Each bit holds for exactly one tick period. `led` updates one cycle after the tick is sampled.
- Total ticks consumed from the first bit to the end of a run: reps×PAT_LEN + (reps-1), because of the gaps.
- `done` asserts in the same cycle that `busy` falls and `led` returns to 0 after the last bit.
- A new `start` is accepted in the cycle after `done`, no sooner.
- Continuous mode (`reps`=0) never asserts `done`. It ends only on `stop` or `rst`.

## Test plan
- PAT_LEN=8, pattern=8'b1011_0001, reps=1, tick every 4 clk → `led` = 1,0,1,1,0,0,0,1 with each value held 4 clk; `done` pulses once; `busy` spans 1+ (ARM wait) + 32 clk.
- Same pattern, reps=3 → 3 copies with a single dark tick between copies (26 ticks total); exactly one `done` pulse, after the third copy.
- reps=0, pattern=8'hFF, run 50 ticks, then assert `stop` in the same cycle as a tick → `led`=0 and `busy`=0 next cycle; `done` never asserts.
- `start` pulsed in the same cycle as a tick → that tick is ignored; the first bit appears on the next tick. A second `start` mid-run with pattern=8'h00 → the output is unchanged.
- Assert `rst` during bit 5 of rep 2 → next cycle all outputs are 0 and state is IDLE; a fresh `start` afterwards runs a clean reps=1 sequence.
- `tick` held low for 100 clk after `start` → the block stays in ARM with `busy`=1, `led`=0, `bit_idx`=0.
